packet_arbiter: RTL and testbench
=================================

PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8, the stream data width in bytes; EMPTY_W = $clog2(DATA_BYTES).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have, for N in {0,1}, the input ports streamN_data [DATA_BYTES*8], streamN_empty [EMPTY_W], streamN_valid, streamN_startofpacket and streamN_endofpacket, each 1 bit where no width is given; these form Avalon-ST sink N.
REQ-005 SHALL have, for N in {0,1}, the output streamN_ready, 1 bit; sink N uses Avalon-ST readyLatency 0.
REQ-006 SHALL have the outputs stream_out_data, stream_out_empty, stream_out_valid, stream_out_startofpacket and stream_out_endofpacket, with the same widths as the sinks; these form the shared source that drives the endian swapper.
REQ-007 SHALL have the input stream_out_ready, 1 bit, with readyLatency 0.
REQ-008 SHALL have the Avalon-MM CSR ports: csr_address input [1:0], csr_read input 1, csr_write input 1, csr_writedata input [31:0], csr_readdata output [31:0], csr_readdatavalid output 1, csr_waitrequest output 1.

Function
REQ-009 SHALL implement a three-state FSM with states IDLE, GRANT0 and GRANT1, plus a register last_grant.
REQ-010 In IDLE, port N SHALL request when streamN_valid=1, streamN_startofpacket=1 and enableN=1.
REQ-011 In IDLE with a single requester N, the FSM SHALL go to GRANTN on the next edge.
REQ-012 In IDLE with both ports requesting, the FSM SHALL grant the port that is not last_grant (round-robin), and SHALL update last_grant to the granted port.
REQ-013 In IDLE, stream_out_valid SHALL be 0; this gives a 1-cycle arbitration bubble before each packet.
REQ-014 In IDLE, stream0_ready and stream1_ready SHALL be 0, except as stated in REQ-015.
REQ-015 In IDLE, when enableN=1 and streamN_valid=1 with startofpacket=0 (an orphan beat), streamN_ready SHALL be 1, the beat SHALL be discarded, and drop_count SHALL increment.
REQ-016 In GRANTN, the stream_out_* data and sideband outputs SHALL equal the streamN_* inputs combinationally.
REQ-017 In GRANTN, stream_out_valid SHALL equal streamN_valid, and streamN_ready SHALL equal stream_out_ready.
REQ-018 In GRANTN, the ready output of the other port SHALL be 0.
REQ-019 In GRANTN, the FSM SHALL return to IDLE on the edge where streamN_valid, stream_out_ready and streamN_endofpacket are all 1; a single-beat packet (SOP and EOP on one beat) ends the grant after that beat.
REQ-020 In GRANTN, a beat with startofpacket=1 SHALL be forwarded unchanged; the grant SHALL still end only on EOP.
REQ-021 In IDLE, stream_out_data, empty, startofpacket and endofpacket SHALL be driven to 0.
REQ-022 pkt_countN SHALL increment on each accepted beat from port N that has startofpacket=1 (valid & ready & SOP).
REQ-023 pkt_count0, pkt_count1 and drop_count SHALL be 32 bits and wrap from 0xFFFFFFFF to 0.
REQ-024 Writing 0 to enableN while in GRANTN SHALL NOT truncate the packet; the new enable value applies only at the next IDLE arbitration.
REQ-025 CSR address 0 SHALL be R/W: bit0 = enable0, bit1 = enable1, bits 31:2 read as 0.
REQ-026 CSR addresses 1, 2 and 3 SHALL be RO and return pkt_count0, pkt_count1 and drop_count respectively; writes to them are ignored.
REQ-027 CSR reads SHALL have a fixed read latency of 1: csr_readdatavalid=1 and csr_readdata valid exactly one cycle after csr_read=1.
REQ-028 csr_readdata SHALL hold its last value when csr_readdatavalid=0.
REQ-029 csr_waitrequest SHALL be tied to 0.
REQ-030 When csr_read and csr_write are asserted in the same cycle, the read SHALL be served and the write SHALL be ignored.
REQ-031 A read of a counter in the same cycle as that counter increments SHALL return the pre-increment value.

Reset
REQ-032 While reset=1, on each clock edge: FSM = IDLE, last_grant = 1 (so port 0 wins the first tie), enable0 = enable1 = 1.
REQ-033 While reset=1, on each clock edge: pkt_count0 = pkt_count1 = drop_count = 0, csr_readdatavalid = 0, csr_readdata = 0.
REQ-034 While reset=1, stream0_ready = stream1_ready = 0 and stream_out_valid = 0.
REQ-035 Reset asserted mid-packet SHALL abandon the grant; the next packet after reset starts with an arbitration bubble.

Verification
REQ-036 Both ports present a 3-beat packet from the same cycle, stream_out_ready=1 -> port 0 forwarded on cycles 1-3, IDLE on cycle 4, port 1 forwarded on cycles 5-7; pkt_count0 = pkt_count1 = 1.
REQ-037 Stall test: port 0 sends a 4-beat packet while stream_out_ready toggles 1,0,1,0,... -> all 4 beats delivered in order with no duplication, and stream1_ready=0 throughout.
REQ-038 Orphan test: port 1 sends a valid beat with SOP=0 while in IDLE -> stream1_ready=1, stream_out_valid stays 0, and CSR read of address 3 returns 1.
REQ-039 Enable test: write 0x1 to address 0 mid-packet from port 1 -> that packet completes; afterwards, port 1 requests are ignored while port 0 is still granted.
REQ-040 CSR test: read address 0 after reset -> csr_readdatavalid=1 exactly one cycle later with csr_readdata = 0x00000003; simultaneous read and write -> write ignored.
REQ-041 Reset test: assert reset on the 2nd beat of a packet -> the next cycle shows IDLE with all counters 0; the retransmitted packet is forwarded after a 1-cycle bubble.

Source files
------------

// File: rtl/packet_arbiter.sv
// Two-input Avalon-ST packet arbiter with round-robin tie-break and an Avalon-MM CSR block.
// Packets are never interleaved: a grant holds from the SOP beat until the EOP beat is accepted.
module packet_arbiter #(
  parameter int DATA_BYTES = 8,
  parameter int EMPTY_W    = $clog2(DATA_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_BYTES*8-1:0] stream0_data,
  input  logic [EMPTY_W-1:0]      stream0_empty,
  input  logic                    stream0_valid,
  input  logic                    stream0_startofpacket,
  input  logic                    stream0_endofpacket,
  output logic                    stream0_ready,
  input  logic [DATA_BYTES*8-1:0] stream1_data,
  input  logic [EMPTY_W-1:0]      stream1_empty,
  input  logic                    stream1_valid,
  input  logic                    stream1_startofpacket,
  input  logic                    stream1_endofpacket,
  output logic                    stream1_ready,
  output logic [DATA_BYTES*8-1:0] stream_out_data,
  output logic [EMPTY_W-1:0]      stream_out_empty,
  output logic                    stream_out_valid,
  output logic                    stream_out_startofpacket,
  output logic                    stream_out_endofpacket,
  input  logic                    stream_out_ready,
  input  logic [1:0]              csr_address,
  input  logic                    csr_read,
  input  logic                    csr_write,
  input  logic [31:0]             csr_writedata,
  output logic [31:0]             csr_readdata,
  output logic                    csr_readdatavalid,
  output logic                    csr_waitrequest
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [1:0]  enable_q, enable_d;
  logic [31:0] pkt_count0_q, pkt_count0_d;
  logic [31:0] pkt_count1_q, pkt_count1_d;
  logic [31:0] drop_count_q, drop_count_d;
  logic [31:0] csr_rdata_q, csr_rdata_d;
  logic        csr_rdvalid_q;
  logic        req0, req1, orphan0, orphan1;
  logic        unused_wdata;

  assign unused_wdata      = ^csr_writedata[31:2];
  assign csr_waitrequest   = 1'b0;
  assign csr_readdata      = csr_rdata_q;
  assign csr_readdatavalid = csr_rdvalid_q;

  always_comb begin
    state_d                  = state_q;
    last_grant_d             = last_grant_q;
    enable_d                 = enable_q;
    pkt_count0_d             = pkt_count0_q;
    pkt_count1_d             = pkt_count1_q;
    drop_count_d             = drop_count_q;
    csr_rdata_d              = csr_rdata_q;
    stream0_ready            = 1'b0;
    stream1_ready            = 1'b0;
    stream_out_data          = '0;
    stream_out_empty         = '0;
    stream_out_valid         = 1'b0;
    stream_out_startofpacket = 1'b0;
    stream_out_endofpacket   = 1'b0;
    req0                     = stream0_valid & stream0_startofpacket & enable_q[0];
    req1                     = stream1_valid & stream1_startofpacket & enable_q[1];
    orphan0                  = stream0_valid & ~stream0_startofpacket & enable_q[0];
    orphan1                  = stream1_valid & ~stream1_startofpacket & enable_q[1];

    // Read wins over a simultaneous write; counters are sampled before this cycle's update.
    if (csr_read) begin
      case (csr_address)
        2'd0:    csr_rdata_d = {30'd0, enable_q};
        2'd1:    csr_rdata_d = pkt_count0_q;
        2'd2:    csr_rdata_d = pkt_count1_q;
        default: csr_rdata_d = drop_count_q;
      endcase
    end else if (csr_write && csr_address == 2'd0) begin
      enable_d = csr_writedata[1:0];
    end

    if (!reset) begin
      case (state_q)
        IDLE: begin
          stream0_ready = orphan0;
          stream1_ready = orphan1;
          drop_count_d  = drop_count_q + {31'd0, orphan0} + {31'd0, orphan1};
          // last_grant_q=1 means port 0 has priority on a tie.
          if (req0 && (!req1 || last_grant_q)) begin
            state_d      = GRANT0;
            last_grant_d = 1'b0;
          end else if (req1) begin
            state_d      = GRANT1;
            last_grant_d = 1'b1;
          end
        end
        GRANT0: begin
          stream_out_data          = stream0_data;
          stream_out_empty         = stream0_empty;
          stream_out_valid         = stream0_valid;
          stream_out_startofpacket = stream0_startofpacket;
          stream_out_endofpacket   = stream0_endofpacket;
          stream0_ready            = stream_out_ready;
          if (stream0_valid && stream_out_ready) begin
            if (stream0_startofpacket) pkt_count0_d = pkt_count0_q + 32'd1;
            if (stream0_endofpacket)   state_d      = IDLE;
          end
        end
        GRANT1: begin
          stream_out_data          = stream1_data;
          stream_out_empty         = stream1_empty;
          stream_out_valid         = stream1_valid;
          stream_out_startofpacket = stream1_startofpacket;
          stream_out_endofpacket   = stream1_endofpacket;
          stream1_ready            = stream_out_ready;
          if (stream1_valid && stream_out_ready) begin
            if (stream1_startofpacket) pkt_count1_d = pkt_count1_q + 32'd1;
            if (stream1_endofpacket)   state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      enable_q      <= 2'b11;
      pkt_count0_q  <= '0;
      pkt_count1_q  <= '0;
      drop_count_q  <= '0;
      csr_rdata_q   <= '0;
      csr_rdvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      enable_q      <= enable_d;
      pkt_count0_q  <= pkt_count0_d;
      pkt_count1_q  <= pkt_count1_d;
      drop_count_q  <= drop_count_d;
      csr_rdata_q   <= csr_rdata_d;
      csr_rdvalid_q <= csr_read;
    end
  end

endmodule

// File: tb/tb_packet_arbiter.sv
// Bench for packet_arbiter: a packet-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations on the delivered beat log and CSRs.
module tb_packet_arbiter;

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  e;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    logic [63:0] d;
    int          c;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] s_data [2];
  logic [2:0]  s_empty[2];
  logic        s_valid[2];
  logic        s_sop  [2];
  logic        s_eop  [2];
  logic        ready0, ready1;
  logic [63:0] o_data;
  logic [2:0]  o_empty;
  logic        o_valid, o_sop, o_eop;
  logic        o_ready;
  logic [1:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic        csr_readdatavalid, csr_waitrequest;

  always #5 clk = ~clk;

  packet_arbiter #(.DATA_BYTES(8)) dut (
    .clk(clk), .reset(reset),
    .stream0_data(s_data[0]), .stream0_empty(s_empty[0]), .stream0_valid(s_valid[0]),
    .stream0_startofpacket(s_sop[0]), .stream0_endofpacket(s_eop[0]), .stream0_ready(ready0),
    .stream1_data(s_data[1]), .stream1_empty(s_empty[1]), .stream1_valid(s_valid[1]),
    .stream1_startofpacket(s_sop[1]), .stream1_endofpacket(s_eop[1]), .stream1_ready(ready1),
    .stream_out_data(o_data), .stream_out_empty(o_empty), .stream_out_valid(o_valid),
    .stream_out_startofpacket(o_sop), .stream_out_endofpacket(o_eop), .stream_out_ready(o_ready),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .csr_readdatavalid(csr_readdatavalid), .csr_waitrequest(csr_waitrequest)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;
  bit r1_seen, ov_seen;
  beat_t q0[$], q1[$];
  ent_t  obs[$];

  // Reference model: owner -1 means no packet in progress.
  int          m_owner = -1, n_owner = -1;
  int          m_last = 1, n_last = 1;
  logic [1:0]  m_en = 2'b11, n_en = 2'b11;
  logic [31:0] m_cnt[3] = '{0, 0, 0};
  logic [31:0] n_cnt[3] = '{0, 0, 0};
  logic        m_rdv = 1'b0, n_rdv = 1'b0;
  logic [31:0] m_rd = '0, n_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] csr_val(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_en};
      2'd1:    return m_cnt[0];
      2'd2:    return m_cnt[1];
      default: return m_cnt[2];
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) started = 1;
    m_owner = n_owner; m_last = n_last; m_en = n_en; m_cnt = n_cnt; m_rdv = n_rdv; m_rd = n_rd;
  end

  always @(negedge clk) begin
    logic [63:0] e_data;
    logic [2:0]  e_empty;
    logic        e_valid, e_sop, e_eop;
    logic        e_r[2], orph[2], req[2];
    int          g;
    if (started) begin
      e_data = '0; e_empty = '0; e_valid = 0; e_sop = 0; e_eop = 0;
      for (int p = 0; p < 2; p++) begin
        e_r[p]  = 0;
        orph[p] = s_valid[p] && !s_sop[p] && m_en[p];
        req[p]  = s_valid[p] && s_sop[p] && m_en[p];
      end
      if (!reset) begin
        if (m_owner < 0) begin
          for (int p = 0; p < 2; p++) e_r[p] = orph[p];
        end else begin
          e_data  = s_data[m_owner];  e_empty = s_empty[m_owner];
          e_valid = s_valid[m_owner]; e_sop   = s_sop[m_owner];
          e_eop   = s_eop[m_owner];   e_r[m_owner] = o_ready;
        end
      end
      chk("out_valid", o_valid, e_valid);
      chk("out_data", o_data, e_data);
      chk("out_empty", o_empty, e_empty);
      chk("out_sop", o_sop, e_sop);
      chk("out_eop", o_eop, e_eop);
      chk("ready0", ready0, e_r[0]);
      chk("ready1", ready1, e_r[1]);
      chk("csr_rdvalid", csr_readdatavalid, m_rdv);
      chk("csr_rdata", csr_readdata, m_rd);
      chk("csr_waitreq", csr_waitrequest, 0);
      if (ready1) r1_seen = 1;
      if (o_valid) ov_seen = 1;
      if (o_valid && o_ready && !reset) obs.push_back('{o_data, cyc});

      n_owner = m_owner; n_last = m_last; n_en = m_en; n_cnt = m_cnt; n_rdv = m_rdv; n_rd = m_rd;
      if (reset) begin
        n_owner = -1; n_last = 1; n_en = 2'b11; n_cnt = '{0, 0, 0}; n_rdv = 0; n_rd = '0;
      end else begin
        n_rdv = csr_read;
        if (csr_read) n_rd = csr_val(csr_address);
        else if (csr_write && csr_address == 2'd0) n_en = csr_writedata[1:0];
        if (m_owner < 0) begin
          for (int p = 0; p < 2; p++) if (orph[p]) n_cnt[2] = n_cnt[2] + 1;
          if (req[0] && req[1]) g = 1 - m_last;
          else if (req[0])      g = 0;
          else if (req[1])      g = 1;
          else                  g = -1;
          if (g >= 0) begin n_owner = g; n_last = g; end
        end else if (s_valid[m_owner] && o_ready) begin
          if (s_sop[m_owner]) n_cnt[m_owner] = n_cnt[m_owner] + 1;
          if (s_eop[m_owner]) n_owner = -1;
        end
      end
    end
  end

  function automatic logic [63:0] getd(input int i);
    return (i < obs.size()) ? obs[i].d : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int getc(input int i);
    return (i < obs.size()) ? obs[i].c : -1;
  endfunction

  task automatic present();
    for (int p = 0; p < 2; p++) begin
      beat_t b;
      logic  v;
      v = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
      b = '0;
      if (v) b = (p == 0) ? q0[0] : q1[0];
      s_valid[p] = v; s_data[p] = b.d; s_empty[p] = b.e; s_sop[p] = b.sop; s_eop[p] = b.eop;
    end
  endtask

  task automatic push_pkt(input int p, input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = base + 64'(i); b.e = b.d[2:0]; b.sop = (i == 0); b.eop = (i == n - 1);
      if (p == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic step(input logic ordy);
    logic hs0, hs1;
    o_ready = ordy;
    @(negedge clk);
    hs0 = s_valid[0] && ready0;
    hs1 = s_valid[1] && ready1;
    @(posedge clk); #1;
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    present();
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    csr_address = a; csr_read = 1;
    @(posedge clk); #1;
    csr_read = 0;
    chk({nm, "_rdv"}, csr_readdatavalid, 1);
    chk(nm, csr_readdata, exp);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] v);
    csr_address = a; csr_writedata = v; csr_write = 1;
    @(posedge clk); #1;
    csr_write = 0;
  endtask

  task automatic chk_log(input string nm, input int first, input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) chk(nm, getd(first + i), base + 64'(i));
  endtask

  initial begin
    int t0;
    csr_address = 0; csr_read = 0; csr_write = 0; csr_writedata = 0; o_ready = 1;
    present();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    csr_rd(2'd0, 32'h3, "csr_en_after_reset");

    // Simultaneous 3-beat packets: port 0 first, one bubble, then port 1.
    obs.delete();
    push_pkt(0, 64'hA0, 3);
    push_pkt(1, 64'hB0, 3);
    present();
    t0 = cyc;
    for (int i = 0; i < 10; i++) step(1);
    chk("rr_count", obs.size(), 6);
    chk_log("rr_p0", 0, 64'hA0, 3);
    chk_log("rr_p1", 3, 64'hB0, 3);
    chk("rr_first_latency", getc(0), t0 + 1);
    chk("rr_bubble", getc(3) - getc(2), 2);
    csr_rd(2'd1, 32'd1, "pkt_count0");
    csr_rd(2'd2, 32'd1, "pkt_count1");
    csr_rd(2'd3, 32'd0, "drop_count0");

    // Stall: stream_out_ready toggles while port 0 sends 4 beats.
    obs.delete(); r1_seen = 0;
    push_pkt(0, 64'hC0, 4);
    present();
    for (int i = 0; i < 10; i++) step(i % 2 == 0);
    chk("stall_count", obs.size(), 4);
    chk_log("stall_order", 0, 64'hC0, 4);
    chk("stall_ready1", r1_seen, 0);
    csr_rd(2'd1, 32'd2, "pkt_count0_stall");

    // Orphan beat on port 1 while idle.
    ov_seen = 0; r1_seen = 0;
    q1.push_back('{64'hD0, 3'd0, 1'b0, 1'b0});
    present();
    step(1);
    step(1);
    chk("orphan_ready1", r1_seen, 1);
    chk("orphan_no_out", ov_seen, 0);
    chk("orphan_consumed", q1.size(), 0);
    csr_rd(2'd3, 32'd1, "drop_count_orphan");

    // Disable port 1 mid-packet: packet completes, later port 1 requests are ignored.
    obs.delete();
    push_pkt(1, 64'hE0, 4);
    present();
    step(1);
    step(1);
    csr_address = 0; csr_writedata = 32'h1; csr_write = 1;
    step(1);
    csr_write = 0;
    push_pkt(0, 64'h60, 2);
    push_pkt(1, 64'hF0, 2);
    present();
    for (int i = 0; i < 10; i++) step(1);
    chk("enable_count", obs.size(), 6);
    chk_log("enable_p1", 0, 64'hE0, 4);
    chk_log("enable_p0", 4, 64'h60, 2);
    chk("enable_p1_held", q1.size(), 2);
    csr_rd(2'd0, 32'h1, "enable_readback");
    q1.delete();
    present();
    csr_wr(2'd0, 32'h3);

    // Read and write together: the read is served, the write is dropped.
    csr_address = 0; csr_writedata = 32'h0; csr_read = 1; csr_write = 1;
    @(posedge clk); #1;
    csr_read = 0; csr_write = 0;
    chk("rw_rdv", csr_readdatavalid, 1);
    chk("rw_rdata", csr_readdata, 32'h3);
    @(posedge clk); #1;
    chk("rdv_deassert", csr_readdatavalid, 0);
    chk("rdata_hold", csr_readdata, 32'h3);
    csr_rd(2'd0, 32'h3, "rw_write_ignored");

    // Reset on the second beat, then retransmit.
    obs.delete();
    push_pkt(0, 64'h90, 4);
    present();
    step(1);
    step(1);
    reset = 1;
    step(1);
    reset = 0;
    q0.delete();
    present();
    csr_rd(2'd1, 32'd0, "rst_pkt0");
    csr_rd(2'd2, 32'd0, "rst_pkt1");
    csr_rd(2'd3, 32'd0, "rst_drop");
    csr_rd(2'd0, 32'h3, "rst_enable");
    obs.delete();
    push_pkt(0, 64'h90, 4);
    present();
    t0 = cyc;
    for (int i = 0; i < 6; i++) step(1);
    chk("retx_count", obs.size(), 4);
    chk_log("retx_data", 0, 64'h90, 4);
    chk("retx_bubble", getc(0), t0 + 1);
    csr_rd(2'd1, 32'd1, "retx_pkt0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
